// File: rtl/axis_input_pipe_multi.sv
// Joins STREAMS lockstep AXI-S pixel streams, strips a per-packet config header and
// expands every input beat into kh1+1 shifted output beats for the conv engine.
module axis_input_pipe_multi #(
  parameter int unsigned STREAMS      = 2,
  parameter int unsigned UNITS        = 4,
  parameter int unsigned WORD_WIDTH   = 8,
  parameter int unsigned KERNEL_H_MAX = 3,
  parameter int unsigned I_KERNEL_H_1 = 0,
  localparam int unsigned IN_WORDS    = 2 ** $clog2(UNITS + KERNEL_H_MAX - 1),
  localparam int unsigned BITS_KH     = ($clog2(KERNEL_H_MAX) > 0) ? $clog2(KERNEL_H_MAX) : 1
) (
  input  logic                                      aclk,
  input  logic                                      areset,
  output logic [STREAMS-1:0]                        s_axis_tready,
  input  logic [STREAMS-1:0]                        s_axis_tvalid,
  input  logic [STREAMS-1:0]                        s_axis_tlast,
  input  logic [STREAMS*IN_WORDS*WORD_WIDTH-1:0]    s_axis_tdata,
  input  logic [STREAMS*IN_WORDS*WORD_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic                                      m_axis_tready,
  output logic                                      m_axis_tvalid,
  output logic                                      m_axis_tlast,
  output logic [STREAMS*UNITS*WORD_WIDTH-1:0]       m_axis_tdata,
  output logic [BITS_KH-1:0]                        m_axis_tuser,
  output logic                                      err_tlast_mismatch
);

  localparam int unsigned HoldW = STREAMS * IN_WORDS * WORD_WIDTH;
  localparam int unsigned OutW  = STREAMS * UNITS * WORD_WIDTH;

  typedef enum logic [1:0] {StHdr, StLoad, StShift} state_e;

  state_e             state_q, state_d;
  logic [BITS_KH-1:0] j_q, j_d;
  logic [BITS_KH-1:0] kh1_q, kh1_d;
  logic               last_q, last_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic               err_q, err_d;

  logic               ready;
  logic               accept;
  logic               last_shift;
  logic               tlast_mixed;
  logic [BITS_KH-1:0] kh_field;
  logic [BITS_KH-1:0] kh_clamped;
  logic [OutW-1:0]    shifted;

  // Full beats are mandatory, so keep is deliberately not consumed.
  logic unused_tkeep;
  assign unused_tkeep = ^s_axis_tkeep;

  assign kh_field    = s_axis_tdata[I_KERNEL_H_1 +: BITS_KH];
  assign kh_clamped  = (32'(kh_field) > KERNEL_H_MAX - 1) ? BITS_KH'(KERNEL_H_MAX - 1) : kh_field;
  assign last_shift  = (j_q == kh1_q);
  assign tlast_mixed = (|s_axis_tlast) && !(&s_axis_tlast);

  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      StHdr, StLoad: ready = 1'b1;
      // Final shift of a non-last beat pulls the next beat in the same cycle.
      StShift:       ready = last_shift && m_axis_tready && !last_q;
      default:       ready = 1'b0;
    endcase
  end

  assign accept = ready && (&s_axis_tvalid);

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    kh1_d   = kh1_q;
    last_d  = last_q;
    hold_d  = hold_q;
    err_d   = err_q | (accept && tlast_mixed);
    unique case (state_q)
      StHdr: begin
        if (accept) begin
          kh1_d = kh_clamped;
          if (s_axis_tlast[0]) begin
            err_d = 1'b1;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (accept) begin
          hold_d  = s_axis_tdata;
          j_d     = '0;
          last_d  = s_axis_tlast[0];
          state_d = StShift;
        end
      end
      StShift: begin
        if (m_axis_tready) begin
          if (!last_shift) begin
            j_d = j_q + BITS_KH'(1);
          end else if (last_q) begin
            j_d     = '0;
            state_d = StHdr;
          end else if (accept) begin
            hold_d = s_axis_tdata;
            j_d    = '0;
            last_d = s_axis_tlast[0];
          end else begin
            j_d     = '0;
            state_d = StLoad;
          end
        end
      end
      default: state_d = StHdr;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= StHdr;
      j_q     <= '0;
      kh1_q   <= '0;
      last_q  <= 1'b0;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      kh1_q   <= kh1_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    shifted = '0;
    for (int s = 0; s < int'(STREAMS); s++) begin
      for (int u = 0; u < int'(UNITS); u++) begin
        shifted[(s * UNITS + u) * WORD_WIDTH +: WORD_WIDTH] =
          hold_q[(s * IN_WORDS + int'(j_q) + u) * WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  // Outputs are forced idle during the reset cycle, whatever state is being cleared.
  assign s_axis_tready      = {STREAMS{ready && !areset}};
  assign m_axis_tvalid      = (state_q == StShift) && !areset;
  assign m_axis_tlast       = m_axis_tvalid && last_q && last_shift;
  assign m_axis_tdata       = areset ? '0 : shifted;
  assign m_axis_tuser       = areset ? '0 : j_q;
  assign err_tlast_mismatch = err_q;

endmodule

// File: tb/tb_axis_input_pipe_multi.sv
// Directed bench for axis_input_pipe_multi (STREAMS=2, UNITS=4, WORD_WIDTH=8, KERNEL_H_MAX=3).
module tb_axis_input_pipe_multi;

  logic         aclk = 1'b0;
  logic         areset;
  logic [1:0]   s_tready, s_tvalid, s_tlast;
  logic [127:0] s_tdata;
  logic [15:0]  s_tkeep;
  logic         m_tready, m_tvalid, m_tlast;
  logic [63:0]  m_tdata;
  logic [1:0]   m_tuser;
  logic         err;

  always #5 aclk = ~aclk;

  axis_input_pipe_multi #(
    .STREAMS(2), .UNITS(4), .WORD_WIDTH(8), .KERNEL_H_MAX(3), .I_KERNEL_H_1(0)
  ) u_dut (
    .aclk               (aclk),
    .areset             (areset),
    .s_axis_tready      (s_tready),
    .s_axis_tvalid      (s_tvalid),
    .s_axis_tlast       (s_tlast),
    .s_axis_tdata       (s_tdata),
    .s_axis_tkeep       (s_tkeep),
    .m_axis_tready      (m_tready),
    .m_axis_tvalid      (m_tvalid),
    .m_axis_tlast       (m_tlast),
    .m_axis_tdata       (m_tdata),
    .m_axis_tuser       (m_tuser),
    .err_tlast_mismatch (err)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  user;
    logic        last;
  } out_t;

  out_t obs_q[$];
  out_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   rdy_mode = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Stream 0 word k = base+k, stream 1 word k = base+0x40+k.
  function automatic logic [127:0] make_beat(input logic [7:0] base);
    logic [127:0] d;
    d = '0;
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 8; k++)
        d[(s * 8 + k) * 8 +: 8] = base + 8'(s * 64) + 8'(k);
    return d;
  endfunction

  // Header: kernel_h-1 in bits [1:0] of stream-0 word 0, junk everywhere else.
  function automatic logic [127:0] hdr(input logic [1:0] kh);
    logic [127:0] d;
    d = {16{8'h5a}};
    d[7:0] = 8'ha4 | {6'b0, kh};
    return d;
  endfunction

  function automatic logic [63:0] exp_tdata(input logic [127:0] beat, input int j);
    logic [63:0] r;
    r = '0;
    for (int s = 0; s < 2; s++)
      for (int u = 0; u < 4; u++)
        r[(s * 4 + u) * 8 +: 8] = beat[(s * 8 + j + u) * 8 +: 8];
    return r;
  endfunction

  function automatic void push_exp(input logic [127:0] beat, input int nshift, input logic last);
    for (int j = 0; j < nshift; j++)
      exp_q.push_back('{exp_tdata(beat, j), 2'(j), last && (j == nshift - 1)});
  endfunction

  // Downstream ready: 0 = always, 1 = random, 2 = never.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        1:       m_tready = 1'($urandom_range(0, 1));
        2:       m_tready = 1'b0;
        default: m_tready = 1'b1;
      endcase
    end
  end

  // Monitor on the falling edge: record handshakes and check stall stability.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [1:0]  prev_user;
  always @(negedge aclk) begin
    if (areset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {63'b0, m_tvalid}, 64'd1);
        check("stall_data", m_tdata, prev_data);
        check("stall_user", {62'b0, m_tuser}, {62'b0, prev_user});
      end
      if (m_tvalid && m_tready) obs_q.push_back('{m_tdata, m_tuser, m_tlast});
      prev_stall <= m_tvalid && !m_tready;
      prev_data  <= m_tdata;
      prev_user  <= m_tuser;
    end
  end

  task automatic send_beat(input logic [127:0] d, input logic [1:0] last, output int waits);
    s_tvalid = 2'b11;
    s_tdata  = d;
    s_tlast  = last;
    waits    = 0;
    while (1) begin
      @(negedge aclk);
      waits++;
      if ((&s_tready) || waits >= 300) break;
    end
    if (!(&s_tready)) check("accept_timeout", 64'd0, 64'd1);
    @(posedge aclk);
    #1;
    s_tvalid = 2'b00;
  endtask

  task automatic expect_outputs(input string tag);
    int n;
    int waits;
    n = exp_q.size();
    waits = 0;
    while (obs_q.size() < n && waits < 400) begin
      @(negedge aclk);
      waits++;
    end
    repeat (4) @(negedge aclk);
    check({tag, "_count"}, 64'(obs_q.size()), 64'(n));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      out_t o;
      out_t e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_data"}, o.data, e.data);
      check({tag, "_user"}, {62'b0, o.user}, {62'b0, e.user});
      check({tag, "_last"}, {63'b0, o.last}, {63'b0, e.last});
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] beat;
    int           w;
    areset   = 1'b1;
    s_tvalid = 2'b00;
    s_tlast  = 2'b00;
    s_tdata  = '0;
    s_tkeep  = '1;

    // Reset state
    @(negedge aclk);
    check("rst_tready", {62'b0, s_tready}, 64'd0);
    check("rst_tvalid", {63'b0, m_tvalid}, 64'd0);
    check("rst_tdata", m_tdata, 64'd0);
    check("rst_tuser", {62'b0, m_tuser}, 64'd0);
    @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check("idle_tready", {62'b0, s_tready}, 64'd3);
    check("idle_tvalid", {63'b0, m_tvalid}, 64'd0);
    check("idle_err", {63'b0, err}, 64'd0);
    @(posedge aclk);
    #1;

    // T1: kh1=2, one last beat -> three shifted windows
    send_beat(hdr(2'd2), 2'b00, w);
    send_beat(make_beat(8'h00), 2'b11, w);
    @(negedge aclk);
    check("t1_latency", {63'b0, m_tvalid}, 64'd1);
    check("t1_first_user", {62'b0, m_tuser}, 64'd0);
    exp_q.push_back('{64'h43424140_03020100, 2'd0, 1'b0});
    exp_q.push_back('{64'h44434241_04030201, 2'd1, 1'b0});
    exp_q.push_back('{64'h45444342_05040302, 2'd2, 1'b1});
    expect_outputs("t1");
    check("t1_hdr_tready", {62'b0, s_tready}, 64'd3);
    @(posedge aclk);
    #1;

    // T2: kh1=0, four back-to-back beats, no bubbles
    send_beat(hdr(2'd0), 2'b00, w);
    check("t2_hdr_wait", 64'(w), 64'd1);
    for (int b = 0; b < 4; b++) begin
      beat = make_beat(8'h10 + 8'(b * 8));
      send_beat(beat, (b == 3) ? 2'b11 : 2'b00, w);
      check("t2_nobubble", 64'(w), 64'd1);
      push_exp(beat, 1, b == 3);
    end
    expect_outputs("t2");
    @(posedge aclk);
    #1;

    // T3: kh1=2 with random downstream stalls
    send_beat(hdr(2'd2), 2'b00, w);
    rdy_mode = 1;
    for (int b = 0; b < 3; b++) begin
      beat = make_beat(8'h80 + 8'(b * 16));
      send_beat(beat, (b == 2) ? 2'b11 : 2'b00, w);
      push_exp(beat, 3, b == 2);
    end
    expect_outputs("t3");
    rdy_mode = 0;
    @(posedge aclk);
    #1;

    // T4: stream 1 valid lags stream 0 by five cycles
    send_beat(hdr(2'd0), 2'b00, w);
    beat     = make_beat(8'hc0);
    s_tdata  = beat;
    s_tlast  = 2'b11;
    s_tvalid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("t4_no_accept", {63'b0, m_tvalid}, 64'd0);
      check("t4_tready_eq", {63'b0, s_tready[1]}, {63'b0, s_tready[0]});
    end
    @(posedge aclk);
    #1;
    send_beat(beat, 2'b11, w);
    check("t4_accept_wait", 64'(w), 64'd1);
    push_exp(beat, 1, 1'b1);
    expect_outputs("t4");
    @(posedge aclk);
    #1;

    // T5: kh field 3 clamps to 2; mixed tlast sets sticky error, stream 0 wins
    send_beat(hdr(2'd3), 2'b00, w);
    beat = make_beat(8'h30);
    send_beat(beat, 2'b01, w);
    push_exp(beat, 3, 1'b1);
    expect_outputs("t5");
    check("t5_err", {63'b0, err}, 64'd1);
    @(posedge aclk);
    #1;
    send_beat(hdr(2'd0), 2'b00, w);
    beat = make_beat(8'h38);
    send_beat(beat, 2'b11, w);
    push_exp(beat, 1, 1'b1);
    expect_outputs("t5b");
    check("t5_err_sticky", {63'b0, err}, 64'd1);
    @(posedge aclk);
    #1;

    // T6: reset mid-shift at j=1, next beat must be taken as a header
    send_beat(hdr(2'd2), 2'b00, w);
    send_beat(make_beat(8'h50), 2'b00, w);
    w = 0;
    while (1) begin
      @(negedge aclk);
      w++;
      if ((m_tvalid && m_tuser == 2'd1) || w >= 50) break;
    end
    check("t6_reach_j1", {62'b0, m_tuser}, 64'd1);
    areset = 1'b1;
    #1;
    check("t6_rst_tvalid", {63'b0, m_tvalid}, 64'd0);
    check("t6_rst_tready", {62'b0, s_tready}, 64'd0);
    @(posedge aclk);
    #1 areset = 1'b0;
    obs_q.delete();
    exp_q.delete();
    @(negedge aclk);
    check("t6_post_tvalid", {63'b0, m_tvalid}, 64'd0);
    check("t6_post_err", {63'b0, err}, 64'd0);
    check("t6_post_tready", {62'b0, s_tready}, 64'd3);
    @(posedge aclk);
    #1;
    send_beat(make_beat(8'h70), 2'b00, w);
    beat = make_beat(8'h78);
    send_beat(beat, 2'b11, w);
    push_exp(beat, 1, 1'b1);
    expect_outputs("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
